// File: rtl/sram_soc_responder.sv
// Unified word RAM behind the core's inst/data SRAM ports, plus a small device-register
// window on the data port. Both ports return read data one cycle after the request.
module sram_soc_responder #(
  parameter int          MEM_AW  = 12,
  parameter logic [15:0] CONF_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out,
  output logic        err
);

  localparam logic [15:0] OFF_SCRATCH0 = 16'h0000;
  localparam logic [15:0] OFF_SCRATCH1 = 16'h0004;
  localparam logic [15:0] OFF_TIMER    = 16'he000;
  localparam logic [15:0] OFF_LED      = 16'hf000;
  localparam logic [15:0] OFF_SWITCH   = 16'hf020;
  localparam logic [15:0] OFF_NUM      = 16'hf030;

  logic [31:0] mem_q [0:(1<<MEM_AW)-1];

  logic [31:0] inst_rdata_q, data_rdata_q;
  logic [31:0] scratch0_q, scratch0_d;
  logic [31:0] scratch1_q, scratch1_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] num_q, num_d;
  logic [15:0] led_q, led_d;
  logic        err_q, err_d;

  logic [MEM_AW-1:0] inst_idx, data_idx;
  logic              dev_sel, dev_wr, ram_wr;
  logic [15:0]       doff;
  logic [31:0]       dev_rdata, led_m;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  assign inst_idx = inst_sram_addr[MEM_AW+1:2];
  assign data_idx = data_sram_addr[MEM_AW+1:2];
  assign doff     = data_sram_addr[15:0];
  assign dev_sel  = (data_sram_addr[31:16] == CONF_HI);
  assign dev_wr   = data_sram_en && dev_sel && (data_sram_wen != 4'h0);
  assign ram_wr   = data_sram_en && !dev_sel && (data_sram_wen != 4'h0);
  assign led_m    = byte_merge({16'h0, led_q}, data_sram_wdata, data_sram_wen);

  always_comb begin
    dev_rdata = 32'h0;
    case (doff)
      OFF_SCRATCH0: dev_rdata = scratch0_q;
      OFF_SCRATCH1: dev_rdata = scratch1_q;
      OFF_TIMER:    dev_rdata = timer_q;
      OFF_LED:      dev_rdata = {16'h0, led_q};
      OFF_SWITCH:   dev_rdata = {16'h0, switch_in};
      OFF_NUM:      dev_rdata = num_q;
      default:      dev_rdata = 32'h0;
    endcase
  end

  // A timer write replaces that cycle's increment.
  always_comb begin
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    num_d      = num_q;
    led_d      = led_q;
    timer_d    = timer_q + 32'd1;
    if (dev_wr) begin
      case (doff)
        OFF_SCRATCH0: scratch0_d = byte_merge(scratch0_q, data_sram_wdata, data_sram_wen);
        OFF_SCRATCH1: scratch1_d = byte_merge(scratch1_q, data_sram_wdata, data_sram_wen);
        OFF_TIMER:    timer_d    = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
        OFF_LED:      led_d      = led_m[15:0];
        OFF_NUM:      num_d      = byte_merge(num_q, data_sram_wdata, data_sram_wen);
        default:      ;
      endcase
    end
    err_d = err_q
          | (inst_sram_en && ((inst_sram_wen != 4'h0) || (inst_sram_addr[1:0] != 2'b00)))
          | (data_sram_en && (data_sram_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      scratch0_q   <= 32'h0;
      scratch1_q   <= 32'h0;
      timer_q      <= 32'h0;
      num_q        <= 32'h0;
      led_q        <= 16'h0;
      err_q        <= 1'b0;
    end else begin
      if (inst_sram_en) inst_rdata_q <= mem_q[inst_idx];
      if (data_sram_en) data_rdata_q <= dev_sel ? dev_rdata : mem_q[data_idx];
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      timer_q    <= timer_d;
      num_q      <= num_d;
      led_q      <= led_d;
      err_q      <= err_d;
    end
  end

  // Non-blocking update makes same-cycle reads on either port see the old word.
  always_ff @(posedge clk) begin
    if (!rst && ram_wr) begin
      for (int b = 0; b < 4; b++)
        if (data_sram_wen[b]) mem_q[data_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{inst_sram_wdata, inst_sram_addr[31:MEM_AW+2], led_m[31:16]};

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;
  assign led_out         = led_q;
  assign num_out         = num_q;
  assign err             = err_q;

endmodule

// File: tb/tb_sram_soc_responder.sv
// Scoreboard bench for sram_soc_responder: directed scenarios followed by random traffic,
// checked against a transaction-level model of the RAM, registers and timer.
module tb_sram_soc_responder;
  localparam logic [15:0] CONF_HI = 16'hbfaf;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [15:0] switch_in, led_out;
  logic [31:0] num_out;
  logic        err;

  always #5 clk = ~clk;

  sram_soc_responder #(.MEM_AW(12), .CONF_HI(CONF_HI)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .switch_in(switch_in), .led_out(led_out), .num_out(num_out), .err(err)
  );

  typedef struct { logic [31:0] v; bit k; } exp_t;
  exp_t iq[$];
  exp_t dq[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model state
  logic [31:0] mm [int];
  logic [31:0] s0, s1, num, tbase;
  logic [15:0] led;
  bit          merr;
  int          ebase;
  int          edge_n = 1;

  function automatic logic [31:0] tmr_at(input int e);
    return tbase + 32'(e - ebase);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic step();
    exp_t ie, de;
    logic [31:0] mask, nv;
    int w;
    if (rst) begin
      s0 = 0; s1 = 0; num = 0; led = 0; merr = 0;
      tbase = 0; ebase = edge_n + 1;
    end else begin
      if (inst_sram_en) begin
        w = int'(inst_sram_addr[13:2]);
        ie.k = mm.exists(w);
        ie.v = ie.k ? mm[w] : 32'h0;
        iq.push_back(ie);
        if (inst_sram_wen != 0 || inst_sram_addr[1:0] != 0) merr = 1;
      end
      if (data_sram_en) begin
        mask = lane_mask(data_sram_wen);
        if (data_sram_addr[1:0] != 0) merr = 1;
        if (data_sram_addr[31:16] == CONF_HI) begin
          de.k = 1;
          case (data_sram_addr[15:0])
            16'h0000: begin de.v = s0;  s0  = (s0 & ~mask) | (data_sram_wdata & mask); end
            16'h0004: begin de.v = s1;  s1  = (s1 & ~mask) | (data_sram_wdata & mask); end
            16'hf030: begin de.v = num; num = (num & ~mask) | (data_sram_wdata & mask); end
            16'hf000: begin
              de.v = {16'h0, led};
              nv   = (de.v & ~mask) | (data_sram_wdata & mask);
              led  = nv[15:0];
            end
            16'he000: begin
              de.v = tmr_at(edge_n);
              if (data_sram_wen != 0) begin
                tbase = (de.v & ~mask) | (data_sram_wdata & mask);
                ebase = edge_n + 1;
              end
            end
            16'hf020: de.v = {16'h0, switch_in};
            default:  de.v = 32'h0;
          endcase
        end else begin
          w = int'(data_sram_addr[13:2]);
          de.k = mm.exists(w);
          de.v = de.k ? mm[w] : 32'h0;
          if (data_sram_wen != 0 && (de.k || mask == 32'hffffffff))
            mm[w] = (de.v & ~mask) | (data_sram_wdata & mask);
        end
        dq.push_back(de);
      end
    end
    @(posedge clk); #1;
    edge_n++;
    check("led_out", {16'h0, led_out}, {16'h0, led});
    check("num_out", num_out, num);
    check("err", {31'h0, err}, {31'h0, merr});
  endtask

  task automatic drv(input bit ie, input logic [3:0] iw, input logic [31:0] ia,
                     input bit de, input logic [3:0] dw, input logic [31:0] da,
                     input logic [31:0] dd);
    inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia;
    inst_sram_wdata = $urandom;
    data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
    step();
  endtask

  task automatic idle();
    drv(0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  // Monitor: pops an expectation whenever the DUT returns data for an accepted request;
  // otherwise rdata must hold its last value.
  bit ip = 0, dp = 0, rr = 0, ik = 0, dk = 0;
  logic [31:0] il = 0, dl = 0;

  always @(posedge clk) begin
    ip <= inst_sram_en && !rst;
    dp <= data_sram_en && !rst;
    rr <= rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rr) begin
      il = 0; ik = 1; dl = 0; dk = 1;
    end else begin
      if (ip) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL inst_queue: got response, expected none queued");
        end else begin
          e = iq.pop_front(); il = e.v; ik = e.k;
        end
      end
      if (dp) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_queue: got response, expected none queued");
        end else begin
          e = dq.pop_front(); dl = e.v; dk = e.k;
        end
      end
    end
    if (ik) check("inst_rdata", inst_sram_rdata, il);
    if (dk) check("data_rdata", data_sram_rdata, dl);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] DEV = {CONF_HI, 16'h0};

  initial begin
    logic [31:0] up [4];
    logic [15:0] offs [8];
    logic [31:0] a;
    up[0] = 32'h0000_0000; up[1] = 32'h0001_0000; up[2] = 32'h8000_0000; up[3] = 32'h0000_4000;
    offs[0] = 16'h0000; offs[1] = 16'h0004; offs[2] = 16'he000; offs[3] = 16'hf000;
    offs[4] = 16'hf020; offs[5] = 16'hf030; offs[6] = 16'h1234; offs[7] = 16'h0008;
    switch_in = 16'h0;
    rst = 1;
    idle(); idle();
    rst = 0;
    idle();

    // Write, read back on both ports, byte lanes, read-first collision
    drv(0, 0, 0, 1, 4'hf, 32'h40, 32'h12345678);
    drv(0, 0, 0, 1, 4'h0, 32'h40, 32'h0);
    drv(1, 0, 32'h40, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 4'b0010, 32'h40, 32'h0000AB00);
    drv(0, 0, 0, 1, 4'h0, 32'h40, 32'h0);
    drv(1, 0, 32'h40, 1, 4'hf, 32'h40, 32'hDEADBEEF);
    drv(1, 0, 32'h40, 0, 0, 0, 0);
    idle();

    // Device window
    drv(0, 0, 0, 1, 4'hf, DEV | 32'hf000, 32'hFFFF_A5A5);
    drv(0, 0, 0, 1, 4'h0, DEV | 32'hf000, 32'h0);
    switch_in = 16'h00C3;
    drv(0, 0, 0, 1, 4'h0, DEV | 32'hf020, 32'h0);
    drv(0, 0, 0, 1, 4'h0, DEV | 32'h1234, 32'h0);
    drv(0, 0, 0, 1, 4'hf, DEV | 32'hf030, 32'hCAFE_0123);
    drv(0, 0, 0, 1, 4'h0, DEV | 32'h0004, 32'h0);

    // Timer wrap, then reset restarts it
    drv(0, 0, 0, 1, 4'hf, DEV | 32'he000, 32'hFFFF_FFFE);
    drv(0, 0, 0, 1, 4'h0, DEV | 32'he000, 32'h0);
    drv(0, 0, 0, 1, 4'h0, DEV | 32'he000, 32'h0);
    drv(0, 0, 0, 1, 4'h0, DEV | 32'he000, 32'h0);
    rst = 1; idle(); rst = 0;
    drv(0, 0, 0, 1, 4'h0, DEV | 32'he000, 32'h0);
    drv(0, 0, 0, 1, 4'h0, DEV | 32'he000, 32'h0);

    // Error conditions and a write lost in a reset cycle
    drv(0, 0, 0, 1, 4'hf, 32'h48, 32'h1111_1111);
    drv(1, 4'h1, 32'h40, 0, 0, 0, 0);
    drv(1, 0, 32'h40, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 4'h0, 32'h42, 32'h0);
    idle();
    rst = 1;
    drv(0, 0, 0, 1, 4'hf, 32'h48, 32'h5555_5555);
    rst = 0;
    drv(0, 0, 0, 1, 4'h0, 32'h48, 32'h0);
    idle();

    // Fill the random working set, then random traffic
    for (int i = 0; i < 16; i++) drv(0, 0, 0, 1, 4'hf, 32'h40 + 32'(4 * i), $urandom);
    for (int n = 0; n < 400; n++) begin
      logic ie, de;
      logic [3:0] iw, dw;
      logic [31:0] ia;
      switch_in = 16'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      ie = $urandom_range(0, 1) == 1;
      iw = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      ia = up[$urandom_range(0, 3)] | (32'h40 + 32'(4 * $urandom_range(0, 15)));
      de = $urandom_range(0, 3) != 0;
      dw = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 2) == 0)
        a = DEV | {16'h0, offs[$urandom_range(0, 7)]};
      else
        a = up[$urandom_range(0, 3)] | (32'h40 + 32'(4 * $urandom_range(0, 15)));
      if ($urandom_range(0, 29) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) ia[1:0] = 2'($urandom_range(1, 3));
      drv(ie, iw, ia, de, dw, a, $urandom);
    end
    rst = 0;
    idle(); idle(); idle();
    check("inst_queue_drained", 32'(iq.size()), 32'h0);
    check("data_queue_drained", 32'(dq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
